// File: rtl/psu_cwdseq.sv
// Codeword-array sequencer: buffers PSU commands in a FIFO and expands each
// into a stream of timestamped per-lane codeword steps over a valid/ready output.
//
// state | meaning
// IDLE  | no command active; pops the FIFO head and emits its step 0
// RUN   | emitting steps 1..len of the active command
module psu_cwdseq #(
    parameter int NUM_PQ     = 16,
    parameter int CWD_BW     = 4,
    parameter int CWD_I      = 0,
    parameter int OPCODE_BW  = 4,
    parameter int IDLEN_BW   = 3,
    parameter int TIME_BW    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [OPCODE_BW-1:0]         cmd_opcode,
    input  logic [NUM_PQ-1:0]            cmd_mask,
    input  logic [NUM_PQ-1:0]            cmd_special,
    input  logic [CWD_BW-1:0]            cmd_cwd,
    input  logic [CWD_BW-1:0]            cmd_cwdsp,
    input  logic [IDLEN_BW-1:0]          cmd_len,
    input  logic [IDLEN_BW:0]            cmd_act,
    input  logic                         cmd_hold,
    input  logic [TIME_BW-1:0]           cmd_tbase,
    input  logic [TIME_BW-1:0]           cmd_tstep,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_PQ*CWD_BW-1:0]     out_cwdarray,
    output logic [TIME_BW-1:0]           out_timing,
    output logic [OPCODE_BW-1:0]         out_opcode,
    output logic [IDLEN_BW-1:0]          out_id,
    output logic                         out_last,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CWD_BW-1:0] CWD_IV  = CWD_BW'(CWD_I);

    typedef struct packed {
        logic [OPCODE_BW-1:0] opcode;
        logic [NUM_PQ-1:0]    mask;
        logic [NUM_PQ-1:0]    special;
        logic [CWD_BW-1:0]    cwd;
        logic [CWD_BW-1:0]    cwdsp;
        logic [IDLEN_BW-1:0]  len;
        logic [IDLEN_BW:0]    act;
        logic                 hold;
        logic [TIME_BW-1:0]   tbase;
        logic [TIME_BW-1:0]   tstep;
    } cmd_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    cmd_t                     mem [FIFO_DEPTH];
    cmd_t                     cmd_in;
    cmd_t                     head;
    cmd_t                     act_q;
    cmd_t                     src;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    state_t                   state_q;
    state_t                   state_d;
    logic                     push;
    logic                     pop;
    logic                     emit;
    logic                     slot_free;
    logic                     fifo_empty;
    logic                     step_last;
    logic [IDLEN_BW-1:0]      step_id;
    logic [TIME_BW-1:0]       step_time;
    logic [NUM_PQ*CWD_BW-1:0] step_cwd;

    assign cmd_in = '{opcode: cmd_opcode, mask: cmd_mask, special: cmd_special,
                      cwd: cmd_cwd, cwdsp: cmd_cwdsp, len: cmd_len, act: cmd_act,
                      hold: cmd_hold, tbase: cmd_tbase, tstep: cmd_tstep};

    assign cmd_ready  = (fifo_count != DEPTH_C);
    assign fifo_empty = (fifo_count == '0);
    assign slot_free  = ~out_valid | out_ready;
    assign push       = cmd_valid & cmd_ready & ~flush;
    assign head       = mem[rd_ptr];

    // Step 0 comes straight from the FIFO head; later steps build on the
    // last emitted step, which the output registers still hold.
    always_comb begin
        src       = (state_q == S_RUN) ? act_q : head;
        step_id   = (state_q == S_RUN) ? out_id + IDLEN_BW'(1) : '0;
        step_time = (state_q == S_RUN) ? out_timing + act_q.tstep : head.tbase;
        step_last = (step_id == src.len);
        step_cwd  = {NUM_PQ{CWD_IV}};
        for (int i = 0; i < NUM_PQ; i++) begin
            // In hold mode a lane past its active window keeps the last active
            // value, which is the lane codeword itself whenever act > 0.
            if (src.mask[i] && (({1'b0, step_id} < src.act) || (src.hold && src.act != '0)))
                step_cwd[i*CWD_BW +: CWD_BW] = src.special[i] ? src.cwdsp : src.cwd;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        emit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && slot_free) begin
                    pop  = 1'b1;
                    emit = 1'b1;
                    if (!step_last)
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (slot_free) begin
                    emit = 1'b1;
                    if (step_last)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            pop     = 1'b0;
            emit    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= cmd_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            act_q        <= '0;
            out_valid    <= 1'b0;
            out_cwdarray <= {NUM_PQ{CWD_IV}};
            out_timing   <= '0;
            out_opcode   <= '0;
            out_id       <= '0;
            out_last     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
            if (pop)
                act_q <= head;
            if (flush)
                out_valid <= 1'b0;
            else if (emit)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (emit) begin
                out_cwdarray <= step_cwd;
                out_timing   <= step_time;
                out_opcode   <= src.opcode;
                out_id       <= step_id;
                out_last     <= step_last;
            end
        end
    end

endmodule

// File: tb/tb_psu_cwdseq.sv
// Bench for psu_cwdseq: directed scenarios plus random traffic, checked against
// a step-list model that expands each accepted command into its output steps.
module tb_psu_cwdseq;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [15:0] cmd_mask;
    logic [15:0] cmd_special;
    logic [3:0]  cmd_cwd;
    logic [3:0]  cmd_cwdsp;
    logic [2:0]  cmd_len;
    logic [3:0]  cmd_act;
    logic        cmd_hold;
    logic [7:0]  cmd_tbase;
    logic [7:0]  cmd_tstep;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_cwdarray;
    logic [7:0]  out_timing;
    logic [3:0]  out_opcode;
    logic [2:0]  out_id;
    logic        out_last;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] mask;
        logic [15:0] special;
        logic [3:0]  cwd;
        logic [3:0]  cwdsp;
        logic [2:0]  len;
        logic [3:0]  act;
        logic        hold;
        logic [7:0]  tbase;
        logic [7:0]  tstep;
    } cmd_s;

    typedef struct {
        logic [63:0] cwd;
        logic [7:0]  t;
        logic [3:0]  op;
        logic [2:0]  id;
        logic        last;
    } exp_t;

    cmd_s        cur;
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    bit          stall_q  = 0;
    logic [63:0] snap_cwd;
    logic [7:0]  snap_t;
    logic [3:0]  snap_op;
    logic [2:0]  snap_id;
    logic        snap_last;

    assign cmd_opcode  = cur.op;
    assign cmd_mask    = cur.mask;
    assign cmd_special = cur.special;
    assign cmd_cwd     = cur.cwd;
    assign cmd_cwdsp   = cur.cwdsp;
    assign cmd_len     = cur.len;
    assign cmd_act     = cur.act;
    assign cmd_hold    = cur.hold;
    assign cmd_tbase   = cur.tbase;
    assign cmd_tstep   = cur.tstep;

    psu_cwdseq #(
        .NUM_PQ(16), .CWD_BW(4), .CWD_I(0), .OPCODE_BW(4),
        .IDLEN_BW(3), .TIME_BW(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_mask(cmd_mask), .cmd_special(cmd_special),
        .cmd_cwd(cmd_cwd), .cmd_cwdsp(cmd_cwdsp), .cmd_len(cmd_len),
        .cmd_act(cmd_act), .cmd_hold(cmd_hold), .cmd_tbase(cmd_tbase),
        .cmd_tstep(cmd_tstep), .out_valid(out_valid), .out_ready(out_ready),
        .out_cwdarray(out_cwdarray), .out_timing(out_timing),
        .out_opcode(out_opcode), .out_id(out_id), .out_last(out_last),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic cmd_s mk_cmd(input logic [3:0] op, input logic [15:0] mask,
                                    input logic [15:0] sp, input logic [3:0] cwd,
                                    input logic [3:0] cwdsp, input logic [2:0] len,
                                    input logic [3:0] act, input logic hold,
                                    input logic [7:0] tbase, input logic [7:0] tstep);
        cmd_s c;
        c.op = op; c.mask = mask; c.special = sp; c.cwd = cwd; c.cwdsp = cwdsp;
        c.len = len; c.act = act; c.hold = hold; c.tbase = tbase; c.tstep = tstep;
        return c;
    endfunction

    function automatic cmd_s rand_cmd();
        return mk_cmd(4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                      4'($urandom), 3'($urandom), 4'($urandom_range(0, 8)),
                      1'($urandom), 8'($urandom), 8'($urandom));
    endfunction

    // Each lane remembers what it last showed; past the active window a held
    // lane repeats that, a flushed lane returns to identity.
    task automatic expand(input cmd_s c);
        logic [3:0] prev [16];
        logic [3:0] v;
        exp_t       e;
        for (int i = 0; i < 16; i++) prev[i] = 4'h0;
        for (int n = 0; n <= int'(c.len); n++) begin
            e.cwd = '0;
            for (int i = 0; i < 16; i++) begin
                v = 4'h0;
                if (c.mask[i]) begin
                    if (n < int'(c.act))
                        v = c.special[i] ? c.cwdsp : c.cwd;
                    else if (c.hold)
                        v = prev[i];
                end
                prev[i] = v;
                e.cwd[i*4 +: 4] = v;
            end
            e.t    = 8'((int'(c.tbase) + n * int'(c.tstep)) % 256);
            e.op   = c.op;
            e.id   = 3'(n);
            e.last = (n == int'(c.len));
            exp_q.push_back(e);
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (stall_q) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_cwd", out_cwdarray, snap_cwd);
            chk("stall_time", out_timing, snap_t);
            chk("stall_op", out_opcode, snap_op);
            chk("stall_id", out_id, snap_id);
            chk("stall_last", out_last, snap_last);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("step_cwd", out_cwdarray, e.cwd);
                chk("step_time", out_timing, e.t);
                chk("step_op", out_opcode, e.op);
                chk("step_id", out_id, e.id);
                chk("step_last", out_last, e.last);
            end
        end
        stall_q   = out_valid && !out_ready && !flush;
        snap_cwd  = out_cwdarray;
        snap_t    = out_timing;
        snap_op   = out_opcode;
        snap_id   = out_id;
        snap_last = out_last;
        if (cmd_valid && cmd_ready && !flush) begin
            expand(cur);
            n_acc++;
        end
        if (flush)
            exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input cmd_s c);
        cur       = c;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 300 && exp_q.size() > 0; k++)
            cycle();
        chk({tag, "_left"}, 64'(exp_q.size()), 0);
        cycle();
        chk({tag, "_idle"}, out_valid, 0);
    endtask

    initial begin
        cmd_s c;
        int   acc0;
        rst       = 1'b1;
        flush     = 1'b0;
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        cur       = mk_cmd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3 rst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_cwd", out_cwdarray, 0);
        chk("rst_time", out_timing, 0);
        chk("rst_op", out_opcode, 0);
        chk("rst_id", out_id, 0);
        chk("rst_last", out_last, 0);
        chk("rst_cnt", fifo_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready, 1);

        // single command, hold mode
        out_ready = 1'b1;
        push_one(mk_cmd(4'h1, 16'h0003, 16'h0002, 4'd5, 4'd9, 3'd2, 4'd1, 1'b1, 8'd10, 8'd3));
        chk("lat_pre_valid", out_valid, 0);
        cycle();
        chk("lat_valid", out_valid, 1);
        chk("hold_s0_cwd", out_cwdarray, 64'h95);
        chk("hold_s0_time", out_timing, 10);
        cycle();
        chk("hold_s1_cwd", out_cwdarray, 64'h95);
        cycle();
        chk("hold_s2_cwd", out_cwdarray, 64'h95);
        chk("hold_s2_time", out_timing, 16);
        chk("hold_s2_last", out_last, 1);
        drain("hold");

        // same command, flush mode
        push_one(mk_cmd(4'h2, 16'h0003, 16'h0002, 4'd5, 4'd9, 3'd2, 4'd1, 1'b0, 8'd10, 8'd3));
        cycle();
        chk("fm_s0_cwd", out_cwdarray, 64'h95);
        cycle();
        chk("fm_s1_cwd", out_cwdarray, 64'h0);
        chk("fm_s1_time", out_timing, 13);
        drain("fm");

        // back-to-back commands with no bubble
        push_one(mk_cmd(4'h3, 16'hF000, 16'h0, 4'd7, 4'd1, 3'd0, 4'd1, 1'b0, 8'd0, 8'd1));
        push_one(mk_cmd(4'h7, 16'h000F, 16'h0, 4'd2, 4'd1, 3'd1, 4'd2, 1'b0, 8'd40, 8'd2));
        chk("b2b_a0_valid", out_valid, 1);
        chk("b2b_a0_op", out_opcode, 4'h3);
        chk("b2b_a0_last", out_last, 1);
        cycle();
        chk("b2b_b0_valid", out_valid, 1);
        chk("b2b_b0_op", out_opcode, 4'h7);
        chk("b2b_b0_id", out_id, 0);
        cycle();
        chk("b2b_b1_valid", out_valid, 1);
        chk("b2b_b1_id", out_id, 1);
        chk("b2b_b1_last", out_last, 1);
        drain("b2b");

        // FIFO full under backpressure
        out_ready = 1'b0;
        acc0      = n_acc;
        for (int k = 0; k < 6; k++) begin
            c    = rand_cmd();
            c.op = 4'(k + 8);
            cur  = c;
            cmd_valid = 1'b1;
            cycle();
        end
        cmd_valid = 1'b0;
        chk("full_accepted", 64'(n_acc - acc0), 5);
        chk("full_cnt", fifo_count, 4);
        chk("full_ready", cmd_ready, 0);
        repeat (3) cycle();
        out_ready = 1'b1;
        drain("full");

        // timestamp wrap
        push_one(mk_cmd(4'h5, 16'h8001, 16'h8000, 4'd3, 4'd12, 3'd3, 4'd2, 1'b1, 8'd250, 8'd4));
        drain("wrap");
        chk("wrap_last_time", out_timing, 6);

        // flush while running with two commands queued
        push_one(mk_cmd(4'h6, 16'hFFFF, 16'h00FF, 4'd1, 4'd2, 3'd7, 4'd8, 1'b0, 8'd0, 8'd1));
        push_one(rand_cmd());
        push_one(rand_cmd());
        chk("flush_pre_cnt", fifo_count, 2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_cnt", fifo_count, 0);
        chk("flush_ready", cmd_ready, 1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("flush_quiet", out_valid, 0);
        end

        // random traffic
        for (int k = 0; k < 400; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cmd_valid = 1'($urandom);
            flush     = ($urandom_range(0, 63) == 0);
            cur       = rand_cmd();
            cycle();
        end
        flush     = 1'b0;
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        drain("rand");

        // asynchronous reset in the middle of a command
        push_one(mk_cmd(4'hC, 16'hFFFF, 16'h0, 4'hA, 4'h0, 3'd7, 4'd8, 1'b1, 8'd77, 8'd1));
        repeat (3) cycle();
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_cwd", out_cwdarray, 0);
        chk("arst_time", out_timing, 0);
        chk("arst_op", out_opcode, 0);
        chk("arst_id", out_id, 0);
        chk("arst_last", out_last, 0);
        chk("arst_cnt", fifo_count, 0);
        exp_q.delete();
        stall_q = 0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_ready", cmd_ready, 1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("arst_quiet", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psu_cwdseq.md
# psu_cwdseq

Parametrised codeword-array sequencer: next-generation PSU output stage. Accepts pre-masked PSU commands into a FIFO of configurable depth and expands each into a multi-step sequence of per-qubit codeword arrays with timestamps. Output uses a valid/ready handshake in place of a global stall. A per-command hold/flush mode selects whether masked lanes keep or drop their codeword after the active window. Sits between mask generation and the codeword generator (cwdgen).

## Interface
Parameters:
- NUM_PQ, 16, physical-qubit lanes in the codeword array
- CWD_BW, 4, codeword width per lane
- CWD_I, 0, identity codeword value
- OPCODE_BW, 4, opcode width
- IDLEN_BW, 3, step-index width; max 2^IDLEN_BW steps per command
- TIME_BW, 8, timestamp width
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (the only clock is clk; reset is async, active-low)
- flush  in  1  synchronous abort: clears FIFO, active command and out_valid
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_opcode  in  OPCODE_BW  opcode, passed through
- cmd_mask  in  NUM_PQ  lanes driven by this command
- cmd_special  in  NUM_PQ  masked lanes using cwdsp instead of cwd
- cmd_cwd, cmd_cwdsp  in  CWD_BW each  normal / special codeword
- cmd_len  in  IDLEN_BW  number of steps minus 1
- cmd_act  in  IDLEN_BW+1  active steps (0..2^IDLEN_BW)
- cmd_hold  in  1  1 = hold mode, 0 = flush mode
- cmd_tbase, cmd_tstep  in  TIME_BW each  first timestamp / per-step increment
- out_valid  out  1  output step present
- out_ready  in  1  downstream accepts
- out_cwdarray  out  NUM_PQ*CWD_BW  lane i at bits [i*CWD_BW +: CWD_BW]
- out_timing  out  TIME_BW  step timestamp
- out_opcode  out  OPCODE_BW  opcode of the command
- out_id  out  IDLEN_BW  step index within the command
- out_last  out  1  final step of the command
- fifo_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- FIFO push when cmd_valid & cmd_ready. cmd_ready = (fifo_count != FIFO_DEPTH); no bypass on full even if a pop occurs in the same cycle.
- Output slot free = ~out_valid | out_ready. A step is produced only when the slot is free.
- FSM IDLE/RUN.
  - IDLE: if FIFO non-empty and slot free, pop head into active registers and emit step 0. Go to RUN if cmd_len>0; otherwise stay in IDLE.
  - RUN: if slot free, emit step id. On id==len, return to IDLE, else id+1. The next command starts in the following cycle, giving zero bubble between commands.
- Lane codeword at step id:
  - Unmasked lane: CWD_I.
  - Masked lane, id < act: cwdsp if special, else cwd.
  - Masked lane, id ≥ act: previous emitted value if hold, else CWD_I. In hold mode with act=0, the lane is CWD_I, because step 0 has no previous value within the command.
- Timestamp: step 0 = tbase; step n = step n-1 + tstep, modulo 2^TIME_BW (wraps silently).
- out_last = (id == len). out_opcode is constant across a command.
- flush has priority over push and pop. It empties the FIFO, sets FSM to IDLE and clears out_valid, all at the same edge. cmd inputs in the flush cycle are dropped.

## Timing
- Reset (rst low, async) values:
  - out_valid=0, out_cwdarray = all CWD_I, out_timing=0, out_opcode=0, out_id=0, out_last=0
  - fifo_count=0, FSM=IDLE, cmd_ready=1 one gate after release
- Latency: a command pushed at edge N is popped at edge N+1 if idle and the slot is free. out_valid is high after edge N+1 with step 0.
- Throughput: one step per cycle while out_ready=1.
- Backpressure: out_valid=1 & out_ready=0 holds all out_* stable. Step counter, timestamp accumulator and FIFO pointers freeze. FIFO may still accept pushes.
- out_valid falls only on a transfer with no new step, or on flush.
- Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- Reset asserted mid-command discards all state immediately; no partial step is emitted after release.

## Test plan
- Single command: mask=0x0003, special=0x0002, cwd=5, cwdsp=9, len=2, act=1, hold=1, tbase=10, tstep=3, out_ready=1.
  - Three steps: lanes[1:0]=(9,5) on all three; timing 10,13,16; out_last only on id 2; other lanes 0.
- Same command with hold=0.
  - Step 0 lanes[1:0]=(9,5); steps 1–2 all lanes 0.
- Back-to-back commands A (len=0) and B (len=1) pushed on consecutive cycles.
  - Outputs A0, B0, B1 on three consecutive cycles, no gap; out_opcode switches at B0.
- FIFO full: hold out_ready=0 and push 6 commands with FIFO_DEPTH=4.
  - 5 pushes accepted (4 in FIFO, 1 in the output slot); cmd_ready=0 with fifo_count=4; outputs held stable.
  - Release out_ready: all 5 commands drain in order.
- Wrap: tbase=250, tstep=4, len=3.
  - Timing 250, 254, 2, 6.
- flush in RUN with 2 commands queued.
  - Next cycle: out_valid=0, fifo_count=0, cmd_ready=1; no further outputs.
- Async rst pulse mid-RUN.
  - Outputs immediately at reset values with no clock edge required.
